// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Reusable inter-stage pipeline register for the pipelined RV32 core. Carries a
// control bundle and a data payload across a stage boundary with a valid/ready
// handshake, NCLR independent flush sources and a defined bubble encoding.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : two-entry storage (main + skid). in_ready is a register equal
//               to !skid_valid, so there is no combinational out_ready ->
//               in_ready path and stop-go back-pressure keeps full throughput.
//   undefined : single entry. in_ready = !out_valid | out_ready
//               (combinational).
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   clr        in   NCLR    flush requests, any bit at logic 1 flushes
//   in_valid   in   1       upstream beat present
//   in_ready   out  1       stage accepts a beat this cycle
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       stage presents a valid beat
//   out_ready  in   1       downstream accepts the beat this cycle
//   out_ctrl   out  CTRL_W  control bundle, BUBBLE_CTRL when out_valid=0
//   out_data   out  DATA_W  payload, zero after reset/flush, held when empty
//   flush_cnt  out  16      saturating count of flushes that discarded a beat
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W      = 96,
    parameter int                 CTRL_W      = 20,
    parameter int                 NCLR        = 2,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCLR-1:0]   clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       flush_cnt
);

    logic              main_valid_reg, main_valid_next;
    logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg,  main_data_next;
    logic [15:0]       flush_cnt_reg,  flush_cnt_next;

    logic push;
    logic pop;
    logic flush;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_reg, skid_valid_next;
    logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic              in_ready_reg,   in_ready_next;

    assign in_ready = in_ready_reg;
`else
    // Single entry: accept when empty or when the held beat leaves this cycle.
    assign in_ready = !main_valid_reg || out_ready;
`endif

    assign push  = in_valid && in_ready;
    assign pop   = main_valid_reg && out_ready;
    // An X on a clr bit makes this X, which the if() below treats as no flush.
    assign flush = |clr;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_ctrl_next  = main_ctrl_reg;
        main_data_next  = main_data_reg;
        flush_cnt_next  = flush_cnt_reg;
`ifdef PIPE_STAGE_SKID_EN
        skid_valid_next = skid_valid_reg;
        skid_ctrl_next  = skid_ctrl_reg;
        skid_data_next  = skid_data_reg;
`endif

        if (flush) begin
            main_valid_next = 1'b0;
            main_ctrl_next  = BUBBLE_CTRL;
            main_data_next  = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_next = 1'b0;
            // Count only flushes that actually threw a beat away.
            if ((main_valid_reg || skid_valid_reg || push) && (flush_cnt_reg != 16'hFFFF))
                flush_cnt_next = flush_cnt_reg + 16'd1;
`else
            if ((main_valid_reg || push) && (flush_cnt_reg != 16'hFFFF))
                flush_cnt_next = flush_cnt_reg + 16'd1;
`endif
        end else begin
            if (!main_valid_reg || pop) begin
`ifdef PIPE_STAGE_SKID_EN
                // Skid holds the older beat, so it must refill main first.
                // in_ready was low while skid was full, so no push can collide.
                if (skid_valid_reg) begin
                    main_valid_next = 1'b1;
                    main_ctrl_next  = skid_ctrl_reg;
                    main_data_next  = skid_data_reg;
                    skid_valid_next = 1'b0;
                end else
`endif
                if (push) begin
                    main_valid_next = 1'b1;
                    main_ctrl_next  = in_ctrl;
                    main_data_next  = in_data;
                end else begin
                    // Going empty: bubble control, payload keeps last value.
                    main_valid_next = 1'b0;
                    main_ctrl_next  = BUBBLE_CTRL;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            else if (push) begin
                skid_valid_next = 1'b1;
                skid_ctrl_next  = in_ctrl;
                skid_data_next  = in_data;
            end
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_comb begin
        in_ready_next = !skid_valid_next;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_ctrl_reg  <= BUBBLE_CTRL;
            main_data_reg  <= '0;
            flush_cnt_reg  <= 16'd0;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_reg <= 1'b0;
            skid_ctrl_reg  <= BUBBLE_CTRL;
            skid_data_reg  <= '0;
            in_ready_reg   <= 1'b1;
`endif
        end else begin
            main_valid_reg <= main_valid_next;
            main_ctrl_reg  <= main_ctrl_next;
            main_data_reg  <= main_data_next;
            flush_cnt_reg  <= flush_cnt_next;
`ifdef PIPE_STAGE_SKID_EN
            skid_valid_reg <= skid_valid_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            skid_data_reg  <= skid_data_next;
            in_ready_reg   <= in_ready_next;
`endif
        end
    end

    assign out_valid = main_valid_reg;
    assign out_ctrl  = main_ctrl_reg;
    assign out_data  = main_data_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule
